// File: rtl/riscv_mem_arb_pkg.sv
// Shared types and widths for the fetch/data single-port RAM arbiter.
package riscv_mem_arb_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned BE_W     = 4;
   localparam int unsigned STARVE_W = 4;

   // Owner of the RAM response due in the next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_e;

   // Load/store port payload
   typedef struct packed {
      logic             we;
      logic [BE_W-1:0]  be;
      logic [XLEN-1:0]  addr;
      logic [XLEN-1:0]  wdata;
   } d_req_t;

endpackage : riscv_mem_arb_pkg

// File: rtl/riscv_arb_prio.sv
// Fetch/data grant selection with a bounded-starvation counter for fetch.
module riscv_arb_prio
   import riscv_mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

   logic [STARVE_W-1:0] r_starve_cnt;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                w_fetch_turn;

   assign w_fetch_turn = i_req && (r_starve_cnt == LIM);

   // Data has priority unless fetch has waited out its allowance
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (d_req && !w_fetch_turn) begin
            d_gnt = 1'b1;
         end else if (i_req) begin
            i_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (i_gnt || !i_req) begin
         w_starve_nxt = '0;
      end else if (d_gnt && (r_starve_cnt != LIM)) begin
         w_starve_nxt = r_starve_cnt + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
      end
   end

endmodule : riscv_arb_prio

// File: rtl/riscv_mem_arb.sv
// Single-port RAM arbiter between instruction fetch and load/store ports.
module riscv_mem_arb
   import riscv_mem_arb_pkg::*;
#(
   parameter int unsigned RAM_AW     = 12,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req,
   input  logic [XLEN-1:0]    i_addr,
   output logic               i_gnt,
   output logic               i_rvalid,
   output logic [XLEN-1:0]    i_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [XLEN-1:0]    d_addr,
   input  logic [BE_W-1:0]    d_be,
   input  logic [XLEN-1:0]    d_wdata,
   output logic               d_gnt,
   output logic               d_rvalid,
   output logic [XLEN-1:0]    d_rdata,
   output logic               d_err,
   output logic               ram_en,
   output logic [BE_W-1:0]    ram_we,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic [XLEN-1:0]    ram_wdata,
   input  logic [XLEN-1:0]    ram_rdata
);

   d_req_t             w_dreq;
   logic [RAM_AW-1:0]  w_i_word;
   logic [RAM_AW-1:0]  w_d_word;
   logic               w_d_oor;
   logic               w_unused_addr_bits;
   arb_owner_e         r_owner;
   arb_owner_e         w_owner_nxt;
   logic               r_d_err;

   assign w_dreq = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};

   // Fetch wraps modulo RAM size; only data addresses are range-checked
   assign w_i_word = i_addr[RAM_AW+1:2];
   assign w_d_word = w_dreq.addr[RAM_AW+1:2];
   assign w_d_oor  = |w_dreq.addr[XLEN-1:RAM_AW+2];

   assign w_unused_addr_bits = ^{i_addr[XLEN-1:RAM_AW+2], i_addr[1:0], w_dreq.addr[1:0]};

   riscv_arb_prio #(
      .STARVE_LIM (STARVE_LIM)
   ) u_prio (
      .clk   (clk),
      .reset (reset),
      .i_req (i_req),
      .d_req (d_req),
      .i_gnt (i_gnt),
      .d_gnt (d_gnt)
   );

   // Out-of-range data grants still complete, but never touch the RAM
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (i_gnt) begin
         ram_en   = 1'b1;
         ram_addr = w_i_word;
      end else if (d_gnt && !w_d_oor) begin
         ram_en   = 1'b1;
         ram_addr = w_d_word;
         if (w_dreq.we) begin
            ram_we    = w_dreq.be;
            ram_wdata = w_dreq.wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner <= OWN_NONE;
         r_d_err <= 1'b0;
      end else begin
         r_owner <= w_owner_nxt;
         r_d_err <= d_gnt && w_d_oor;
      end
   end

   // Owner next-state and response routing; reset masks a response in flight
   always_comb begin
      w_owner_nxt = OWN_NONE;
      i_rvalid    = 1'b0;
      i_rdata     = '0;
      d_rvalid    = 1'b0;
      d_rdata     = '0;
      d_err       = 1'b0;

      if (i_gnt) begin
         w_owner_nxt = OWN_I;
      end else if (d_gnt && !w_dreq.we) begin
         w_owner_nxt = OWN_D;
      end

      if (!reset) begin
         d_err = r_d_err;
         case (r_owner)
            OWN_I: begin
               i_rvalid = 1'b1;
               i_rdata  = ram_rdata;
            end
            OWN_D: begin
               d_rvalid = 1'b1;
               d_rdata  = r_d_err ? '0 : ram_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule : riscv_mem_arb

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb with a behavioural RAM and a response scoreboard.
module tb_riscv_mem_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   typedef struct {
      logic        port_i;
      logic [31:0] data;
      logic        err;
      logic        is_store;
      int unsigned due;
   } resp_t;

   resp_t       sb[$];
   resp_t       mon_e;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   riscv_mem_arb #(.RAM_AW(12), .STARVE_LIM(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [31:0] pre(input int unsigned w);
      case (w)
         0:       return 32'h11;
         1:       return 32'h22;
         2:       return 32'h33;
         16:      return 32'h0;
         default: return 32'hC000_0000 | 32'(w);
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Behavioural synchronous RAM, reloaded while reset is high
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4096; i++) mem[i] <= pre(i);
      end else if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we != 4'h0) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Compare every cycle's response outputs against the scoreboard head
   always @(posedge clk) begin
      logic        ev_i, ev_d, ee;
      logic [31:0] er_i, er_d;
      #2;
      ev_i = 1'b0; ev_d = 1'b0; ee = 1'b0; er_i = 32'h0; er_d = 32'h0;
      if (sb.size() != 0 && sb[0].due == cyc) begin
         mon_e = sb.pop_front();
         ev_i  = mon_e.port_i;
         ev_d  = !mon_e.port_i && !mon_e.is_store;
         er_i  = ev_i ? mon_e.data : 32'h0;
         er_d  = ev_d ? mon_e.data : 32'h0;
         ee    = mon_e.err;
      end
      chk("i_rvalid", 32'(i_rvalid), 32'(ev_i));
      chk("i_rdata",  i_rdata, er_i);
      chk("d_rvalid", 32'(d_rvalid), 32'(ev_d));
      chk("d_rdata",  d_rdata, er_d);
      chk("d_err",    32'(d_err), 32'(ee));
   end

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [3:0] db, input logic [31:0] dd);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_be = db; d_wdata = dd;
   endtask

   task automatic expect_cycle(input string tag, input logic eig, input logic edg,
                               input logic een, input logic [3:0] ewe, input logic [31:0] eaddr);
      @(negedge clk);
      chk({tag, ".i_gnt"},    32'(i_gnt),    32'(eig));
      chk({tag, ".d_gnt"},    32'(d_gnt),    32'(edg));
      chk({tag, ".ram_en"},   32'(ram_en),   32'(een));
      chk({tag, ".ram_we"},   32'(ram_we),   32'(ewe));
      chk({tag, ".ram_addr"}, 32'(ram_addr), eaddr);
   endtask

   task automatic push_resp(input logic pi, input logic [31:0] data, input logic err,
                            input logic st);
      sb.push_back('{port_i: pi, data: data, err: err, is_store: st, due: cyc + 1});
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // One contention cycle; data address advances only on a data grant
   task automatic both_step(input string tag, input logic ireq, input logic exp_fetch,
                            inout int unsigned dk);
      drive(ireq, 32'h200, 1'b1, 1'b0, 32'h400 + 4 * dk, 4'h0, 32'h0);
      if (exp_fetch) begin
         expect_cycle(tag, 1'b1, 1'b0, 1'b1, 4'h0, 32'h80);
         push_resp(1'b1, pre(32'h80), 1'b0, 1'b0);
      end else begin
         expect_cycle(tag, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100 + dk);
         push_resp(1'b0, pre(32'h100 + dk), 1'b0, 1'b0);
         dk++;
      end
      adv();
   endtask

   initial begin
      int unsigned dk;
      dk    = 0;
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      expect_cycle("reset", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      adv();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      adv();

      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         expect_cycle("fetch", 1'b1, 1'b0, 1'b1, 4'h0, 32'(k));
         push_resp(1'b1, pre(k), 1'b0, 1'b0);
         adv();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      adv();

      for (int k = 0; k < 10; k++) both_step("contend", 1'b1, (k % 5) == 4, dk);
      both_step("clr_a", 1'b1, 1'b0, dk);
      both_step("clr_a", 1'b1, 1'b0, dk);
      both_step("clr_donly", 1'b0, 1'b0, dk);
      for (int k = 0; k < 5; k++) both_step("clr_b", 1'b1, k == 4, dk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      adv();

      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF);
      expect_cycle("store", 1'b0, 1'b1, 1'b1, 4'b0011, 32'h10);
      chk("store.ram_wdata", ram_wdata, 32'hDEAD_BEEF);
      adv();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      expect_cycle("load", 1'b0, 1'b1, 1'b1, 4'h0, 32'h10);
      push_resp(1'b0, 32'h0000_BEEF, 1'b0, 1'b0);
      adv();

      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
      expect_cycle("oor_ld", 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      push_resp(1'b0, 32'h0, 1'b1, 1'b0);
      adv();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_0040, 4'hF, 32'h1234_5678);
      expect_cycle("oor_st", 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      push_resp(1'b0, 32'h0, 1'b1, 1'b1);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      adv();

      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      expect_cycle("rmr_gnt", 1'b1, 1'b0, 1'b1, 4'h0, 32'h2);
      adv();
      reset = 1'b1;
      expect_cycle("rmr_rst", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      adv();
      reset = 1'b0;
      expect_cycle("rmr_first", 1'b1, 1'b0, 1'b1, 4'h0, 32'h2);
      push_resp(1'b1, pre(2), 1'b0, 1'b0);
      adv();

      drive(1'b1, 32'h0000_4004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      expect_cycle("wrap", 1'b1, 1'b0, 1'b1, 4'h0, 32'h1);
      push_resp(1'b1, pre(1), 1'b0, 1'b0);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (3) adv();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_riscv_mem_arb
